heichips25_result_serializer: RTL and testbench
===============================================

HEICHIPS25_RESULT_SERIALIZER -- requirements
Module: heichips25_result_serializer

Interface
REQ-001 SHALL have parameter N, default 4, meaning systolic array dimension (N x N results).
REQ-002 SHALL have parameter RW, default 8, meaning result word width in bits; legal values 8 and 16.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port res_data  input  N*N*RW  flattened array results; word k at bits [k*RW +: RW], k = row*N + col.
REQ-006 SHALL have port res_valid  input  1  one-cycle pulse from the array's valid output marking res_data valid.
REQ-007 SHALL have port out_data  output  8  streamed result byte.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid byte.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the byte when out_valid and out_ready are both high.
REQ-010 SHALL have port out_sof  output  1  high with the first byte of a frame.
REQ-011 SHALL have port out_eof  output  1  high with the last byte of a frame.
REQ-012 SHALL have port busy  output  1  high while a frame is held or being sent.
REQ-013 SHALL have port overflow  output  1  sticky flag: a res_valid pulse was dropped.
REQ-014 SHALL have port clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-015 SHALL implement states IDLE and SEND only.
REQ-016 IDLE: on res_valid SHALL capture all of res_data into an internal snapshot register, reset word index and byte index to 0, and go to SEND.
REQ-017 SHALL assert out_valid in the cycle after the capturing res_valid (latency 1).
REQ-018 Byte order SHALL be word 0 first, ascending k to N*N-1; within a word, least-significant byte first; RW/8 bytes per word; frame length N*N*RW/8 bytes.
REQ-019 In SEND, out_valid SHALL stay high; out_data, out_sof, out_eof SHALL stay stable while out_valid && !out_ready.
REQ-020 Each accepted byte SHALL advance byte index, wrapping to 0 and incrementing word index after RW/8 bytes.
REQ-021 out_sof SHALL be high only for word 0, byte 0; out_eof only for word N*N-1, last byte.
REQ-022 Acceptance of the eof byte SHALL return to IDLE, unless REQ-024 applies.
REQ-023 res_valid in SEND, other than the REQ-024 case, SHALL be ignored (snapshot unchanged) and SHALL set overflow.
REQ-024 res_valid in the same cycle the eof byte is accepted SHALL capture the new snapshot and remain in SEND with indices at 0 (back-to-back frames, no gap, no overflow).
REQ-025 In the IDLE state, out_valid, out_sof, out_eof SHALL be 0; out_data SHALL be 0.
REQ-026 busy SHALL equal (state == SEND).
REQ-027 clr_ovf SHALL clear overflow; a same-cycle set (REQ-023) SHALL take priority over clr_ovf.
REQ-028 Word and byte counters SHALL be sized to $clog2 of their ranges; no arithmetic on result data (pass-through only).

Reset
REQ-029 reset SHALL dominate all other inputs in the same cycle.
REQ-030 On reset: state IDLE, out_valid 0, out_data 0, out_sof 0, out_eof 0, busy 0, overflow 0, indices 0; snapshot contents need not be cleared.
REQ-031 reset mid-frame SHALL abort the frame; no further bytes of it SHALL be emitted.

Verification (N=4, RW=8, res_data word k = k+1)
REQ-032 Basic: res_valid pulse, out_ready held 1 -> 16 consecutive bytes 0x01..0x10, sof on 0x01, eof on 0x10, busy low the cycle after eof.
REQ-033 Backpressure: out_ready toggled 1,0,0,1 repeating -> same byte sequence, each byte held stable while stalled, no byte duplicated or skipped.
REQ-034 Overflow: second res_valid at byte 5 -> stream still 0x01..0x10 unchanged, overflow=1 until clr_ovf pulse, then 0.
REQ-035 Back-to-back: second res_valid (words = k+0x21) in the eof-accept cycle -> next cycle sof with 0x21, 32 bytes total without gap, overflow=0.
REQ-036 Reset mid-frame: reset after byte 7 accepted -> next cycle out_valid=0, busy=0; new res_valid restarts at 0x01 with sof.
REQ-037 RW=16 build: word k = 0x0100+k -> bytes 0x00,0x01,0x01,0x01,... low byte first, 32 bytes, eof on 0x01 (high byte of word 15).

Source files
------------

// File: rtl/heichips25_result_serializer.sv
// Streams an N x N systolic-array result snapshot out as a byte frame with
// sof/eof markers, valid/ready flow control and a sticky overflow flag.
module heichips25_result_serializer #(
    parameter int N  = 4,
    parameter int RW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N*N*RW-1:0] res_data,
    input  logic              res_valid,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic              busy,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam int WORDS = N * N;
    localparam int BPW   = RW / 8;
    localparam int FRAME = WORDS * BPW;
    localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BW    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int LW    = (FRAME > 1) ? $clog2(FRAME) : 1;

    // Handshake: a byte transfers on any rising edge where out_valid && out_ready;
    // out_data/out_sof/out_eof hold while out_valid && !out_ready.
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t              r_state;
    logic [N*N*RW-1:0]   r_snap;
    logic [WW-1:0]       r_word_idx;
    logic [BW-1:0]       r_byte_idx;
    logic [7:0]          r_out_data;
    logic                r_out_valid;
    logic                r_out_sof;
    logic                r_out_eof;
    logic                r_overflow;

    logic [7:0]          w_bytes [FRAME];
    logic                w_accept;
    logic                w_eof_accept;
    logic                w_capture;
    logic                w_drop;
    logic [WW-1:0]       w_next_word;
    logic [BW-1:0]       w_next_byte;
    logic [LW-1:0]       w_next_lin;
    logic                w_next_eof;

    // Byte view of the snapshot in stream order (low byte of each word first).
    for (genvar g = 0; g < FRAME; g++) begin : g_bytes
        assign w_bytes[g] = r_snap[g*8 +: 8];
    end

    assign w_accept     = r_out_valid && out_ready;
    assign w_eof_accept = w_accept && r_out_eof;
    assign w_capture    = res_valid && ((r_state == IDLE) || w_eof_accept);
    assign w_drop       = res_valid && (r_state == SEND) && !w_eof_accept;

    always_comb begin
        w_next_word = r_word_idx;
        w_next_byte = r_byte_idx + BW'(1);
        if (r_byte_idx == BW'(BPW - 1)) begin
            w_next_byte = '0;
            w_next_word = r_word_idx + WW'(1);
        end
        w_next_lin = LW'(w_next_word) * LW'(BPW) + LW'(w_next_byte);
        w_next_eof = (w_next_word == WW'(WORDS - 1)) && (w_next_byte == BW'(BPW - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_word_idx  <= '0;
            r_byte_idx  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end

            // A capture on the eof-accept edge chains the next frame with no gap.
            if (w_capture) begin
                r_state     <= SEND;
                r_snap      <= res_data;
                r_word_idx  <= '0;
                r_byte_idx  <= '0;
                r_out_data  <= res_data[7:0];
                r_out_valid <= 1'b1;
                r_out_sof   <= 1'b1;
                r_out_eof   <= (FRAME == 1);
            end else if (w_eof_accept) begin
                r_state     <= IDLE;
                r_word_idx  <= '0;
                r_byte_idx  <= '0;
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
                r_out_sof   <= 1'b0;
                r_out_eof   <= 1'b0;
            end else if (w_accept) begin
                r_word_idx  <= w_next_word;
                r_byte_idx  <= w_next_byte;
                r_out_data  <= w_bytes[w_next_lin];
                r_out_sof   <= 1'b0;
                r_out_eof   <= w_next_eof;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;
    assign busy      = (r_state == SEND);
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_heichips25_result_serializer.sv
// Bench for the result serializer: an 8-bit-word and a 16-bit-word instance
// run side by side against a byte-queue model of the frame stream.
module tb_heichips25_result_serializer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          res_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [127:0]  rd8 = '0;
    logic [255:0]  rd16 = '0;

    logic [7:0] o8_data, o16_data;
    logic o8_valid, o8_sof, o8_eof, o8_busy, o8_ovf;
    logic o16_valid, o16_sof, o16_eof, o16_busy, o16_ovf;

    heichips25_result_serializer #(.N(4), .RW(8)) dut8 (
        .clk(clk), .reset(reset), .res_data(rd8), .res_valid(res_valid),
        .out_data(o8_data), .out_valid(o8_valid), .out_ready(out_ready),
        .out_sof(o8_sof), .out_eof(o8_eof), .busy(o8_busy),
        .overflow(o8_ovf), .clr_ovf(clr_ovf)
    );

    heichips25_result_serializer #(.N(4), .RW(16)) dut16 (
        .clk(clk), .reset(reset), .res_data(rd16), .res_valid(res_valid),
        .out_data(o16_data), .out_valid(o16_valid), .out_ready(out_ready),
        .out_sof(o16_sof), .out_eof(o16_eof), .busy(o16_busy),
        .overflow(o16_ovf), .clr_ovf(clr_ovf)
    );

    // ---------------- model / scoreboard ----------------
    // Entries are {sof, eof, byte}, queued whole at the moment a frame is captured.
    logic [9:0] exp_q8[$];
    logic [9:0] exp_q16[$];
    logic       ovf8_m = 1'b0;
    logic       ovf16_m = 1'b0;
    logic [7:0]  w8  [16];
    logic [15:0] w16 [16];
    int n_cmp = 0;
    int n_err = 0;
    int n_cycles = 0;
    int rdy_mode = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string nm, input logic v, input logic sof, input logic eof,
                              input logic [7:0] d, input logic b, input logic ov,
                              input int qs, input logic [9:0] hd, input logic ovm);
        chk({nm, ".valid"}, 32'(v), 32'(qs > 0));
        if (qs > 0) chk({nm, ".byte"}, 32'({sof, eof, d}), 32'(hd));
        else        chk({nm, ".idle_out"}, 32'({sof, eof, d}), 32'd0);
        chk({nm, ".busy"}, 32'(b), 32'(qs > 0));
        chk({nm, ".overflow"}, 32'(ov), 32'(ovm));
    endtask

    task automatic push_frames();
        for (int k = 0; k < 16; k++)
            exp_q8.push_back({k == 0, k == 15, w8[k]});
        for (int k = 0; k < 16; k++)
            for (int b = 0; b < 2; b++)
                exp_q16.push_back({(k == 0) && (b == 0), (k == 15) && (b == 1), w16[k][b*8 +: 8]});
    endtask

    // One clock: check outputs, advance the model with the current inputs, step.
    task automatic cycle();
        logic set8, set16;
        check_inst("rw8", o8_valid, o8_sof, o8_eof, o8_data, o8_busy, o8_ovf,
                   exp_q8.size(), (exp_q8.size() > 0) ? exp_q8[0] : 10'd0, ovf8_m);
        check_inst("rw16", o16_valid, o16_sof, o16_eof, o16_data, o16_busy, o16_ovf,
                   exp_q16.size(), (exp_q16.size() > 0) ? exp_q16[0] : 10'd0, ovf16_m);
        if (reset) begin
            exp_q8.delete();
            exp_q16.delete();
            ovf8_m  = 1'b0;
            ovf16_m = 1'b0;
        end else begin
            if (exp_q8.size() > 0 && out_ready) void'(exp_q8.pop_front());
            if (exp_q16.size() > 0 && out_ready) void'(exp_q16.pop_front());
            set8  = res_valid && (exp_q8.size() != 0);
            set16 = res_valid && (exp_q16.size() != 0);
            if (res_valid) begin
                if (exp_q8.size() == 0) begin
                    for (int k = 0; k < 16; k++) exp_q8.push_back({k == 0, k == 15, w8[k]});
                end
                if (exp_q16.size() == 0) begin
                    for (int k = 0; k < 16; k++)
                        for (int b = 0; b < 2; b++)
                            exp_q16.push_back({(k == 0) && (b == 0), (k == 15) && (b == 1),
                                               w16[k][b*8 +: 8]});
                end
            end
            if (set8) ovf8_m = 1'b1;
            else if (clr_ovf) ovf8_m = 1'b0;
            if (set16) ovf16_m = 1'b1;
            else if (clr_ovf) ovf16_m = 1'b0;
        end
        @(posedge clk);
        #1;
        n_cycles++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic load(input int mode);
        for (int k = 0; k < 16; k++) begin
            case (mode)
                0:       begin w8[k] = 8'(k + 1);      w16[k] = 16'(16'h0100 + k); end
                1:       begin w8[k] = 8'(k + 'h21);   w16[k] = 16'(16'h2100 + k); end
                3:       begin w8[k] = 8'(8'hA0 + k);  w16[k] = 16'(16'hA000 + k); end
                default: begin w8[k] = 8'($urandom_range(0, 255)); w16[k] = 16'($urandom_range(0, 65535)); end
            endcase
            rd8[k*8 +: 8]   = w8[k];
            rd16[k*16 +: 16] = w16[k];
        end
    endtask

    task automatic set_ready();
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((n_cycles % 4) == 0) || ((n_cycles % 4) == 3);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            set_ready();
            cycle();
        end
    endtask

    task automatic pulse(input int mode, input logic clr);
        load(mode);
        res_valid = 1'b1;
        clr_ovf   = clr;
        set_ready();
        cycle();
        res_valid = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        load(0);
        @(posedge clk);
        #1;
        run(2);                       // reset state checked with reset held
        reset = 1'b0;
        run(2);

        // basic frame, ready held high
        rdy_mode = 0;
        pulse(0, 1'b0);
        run(40);

        // backpressure 1,0,0,1
        rdy_mode = 1;
        pulse(0, 1'b0);
        run(80);

        // overflow mid-frame, then overflow set wins over a same-cycle clear
        rdy_mode = 0;
        pulse(0, 1'b0);
        run(4);
        pulse(3, 1'b0);
        run(3);
        pulse(3, 1'b1);
        run(40);
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        run(3);

        // back-to-back: second capture on the eof-accept edge of the 8-bit stream
        pulse(0, 1'b0);
        for (int i = 0; i < 40 && exp_q8.size() != 1; i++) run(1);
        if (exp_q8.size() != 1) begin
            n_cmp++;
            n_err++;
            $error("FAIL b2b_reach observed=%0d expected=1", exp_q8.size());
        end
        pulse(1, 1'b0);
        run(50);
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;

        // reset after seven accepted bytes, then a clean restart
        pulse(0, 1'b0);
        run(7);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run(2);
        pulse(0, 1'b0);
        run(40);

        // randomized traffic
        rdy_mode = 2;
        for (int i = 0; i < 800; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            clr_ovf   = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0) begin
                load(2);
                res_valid = 1'b1;
            end else begin
                res_valid = 1'b0;
            end
            set_ready();
            cycle();
        end
        reset = 1'b0;
        res_valid = 1'b0;
        clr_ovf = 1'b0;
        rdy_mode = 0;
        run(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
